// File: rtl/arb_rr_4_pkg.sv
// ============================================================================
// Module : arb_rr_4_pkg
// Brief  : Shared constants and types for the 4-way round-robin arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package arb_rr_4_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic [0:0] {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

  function automatic logic [N_REQ-1:0] sel_onehot(input sel_t s);
    logic [N_REQ-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick_4.sv
// ============================================================================
// Module : rr_pick_4
// Brief  : Combinational rotate-and-priority pick: first valid index after last.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick_4
  import arb_rr_4_pkg::*;
(
  input  logic [N_REQ-1:0] valid,
  input  sel_t             last,
  output logic             any,
  output sel_t             idx
);

  sel_t w_cand;

  // Scan offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    any    = 1'b0;
    idx    = last;
    w_cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = last + sel_t'(k);
      if (valid[w_cand]) begin
        any = 1'b1;
        idx = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/arb_rr_4.sv
// ============================================================================
// Module : arb_rr_4
// Brief  : 4-way round-robin arbiter into a one-entry registered output.
//          Define ARB_RR_4_LOCK_EN to hold the grant until an in_last beat.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_rr_4
  import arb_rr_4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [N_REQ-1:0] in_valid,
  input  logic [N_REQ-1:0] in_last,
  output logic [N_REQ-1:0] in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output sel_t             out_sel
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  sel_t             r_out_sel;
  sel_t             r_last_grant;

  logic             w_load_en;
  logic             w_rr_any;
  sel_t             w_rr_idx;
  logic             w_pick_any;
  sel_t             w_pick_idx;
  logic             w_xfer;
  logic [WIDTH-1:0] w_pick_data;

  rr_pick_4 u_pick (
    .valid (in_valid),
    .last  (r_last_grant),
    .any   (w_rr_any),
    .idx   (w_rr_idx)
  );

  assign w_load_en = ~r_out_valid | out_ready;

`ifdef ARB_RR_4_LOCK_EN
  lock_state_t r_lock_state;
  lock_state_t w_lock_next;

  // While locked, only the last-granted requester may transfer; a gap stalls.
  always_comb begin
    w_pick_any = w_rr_any;
    w_pick_idx = w_rr_idx;
    if (r_lock_state == LOCK_HELD) begin
      w_pick_any = in_valid[r_last_grant];
      w_pick_idx = r_last_grant;
    end
  end

  always_comb begin
    w_lock_next = r_lock_state;
    if (w_xfer) begin
      w_lock_next = in_last[w_pick_idx] ? LOCK_IDLE : LOCK_HELD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_state <= LOCK_IDLE;
    end else begin
      r_lock_state <= w_lock_next;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = ^in_last;
  assign w_pick_any    = w_rr_any;
  assign w_pick_idx    = w_rr_idx;
`endif

  assign w_xfer   = w_pick_any & w_load_en & ~rst;
  assign in_ready = w_xfer ? sel_onehot(w_pick_idx) : '0;

  always_comb begin
    w_pick_data = d0;
    case (w_pick_idx)
      2'd1:    w_pick_data = d1;
      2'd2:    w_pick_data = d2;
      2'd3:    w_pick_data = d3;
      default: w_pick_data = d0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sel    <= '0;
      r_last_grant <= 2'd3;
    end else if (w_xfer) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= w_pick_data;
      r_out_sel    <= w_pick_idx;
      r_last_grant <= w_pick_idx;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

`default_nettype wire

// File: tb/tb_arb_rr_4.sv
// ============================================================================
// Module : tb_arb_rr_4
// Brief  : Directed self-checking bench for arb_rr_4 (honours ARB_RR_4_LOCK_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arb_rr_4;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [3:0]       in_valid, in_last, in_ready;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;

  int n_checks = 0;
  int n_errors = 0;

  arb_rr_4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [3:0] exp_data [4];

  initial begin
    exp_data[0] = 4'hA; exp_data[1] = 4'hB; exp_data[2] = 4'hC; exp_data[3] = 4'hD;
    d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
    in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;

    // Reset state, with requests pending
    rst = 1'b1;
    step();
    check("rst_in_ready", in_ready, 4'b0000);
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 4'h0);
    check("rst_out_sel", out_sel, 2'd0);
    rst = 1'b0;
    #1;

    // Full rotation with all requesters valid
    check("rot_first_ready", in_ready, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      step();
      check("rot_valid", out_valid, 1'b1);
      check("rot_sel", out_sel, k % 4);
      check("rot_data", out_data, exp_data[k % 4]);
      check("rot_ready", in_ready, 4'b0001 << ((k + 1) % 4));
    end

    // Backpressure holds the beat
    out_ready = 1'b0;
    #1;
    check("stall_ready0", in_ready, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_valid", out_valid, 1'b1);
      check("stall_sel", out_sel, 2'd0);
      check("stall_data", out_data, 4'hA);
      check("stall_ready", in_ready, 4'b0000);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_ready", in_ready, 4'b0010);
    step();
    check("unstall_sel", out_sel, 2'd1);
    check("unstall_data", out_data, 4'hB);

    // Sparse requesters 0 and 2 alternate
    in_valid = 4'b0101;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("alt_ready", in_ready, (k % 2 == 0) ? 4'b0100 : 4'b0001);
      step();
      check("alt_sel", out_sel, (k % 2 == 0) ? 2'd2 : 2'd0);
    end

    // No requests: drain, and last grant stays at 0
    in_valid = 4'b0000;
    #1;
    check("idle_ready", in_ready, 4'b0000);
    step();
    check("idle_drain", out_valid, 1'b0);
    step();
    check("idle_still", out_valid, 1'b0);
    in_valid = 4'b1111;
    #1;
    check("resume_ready", in_ready, 4'b0010);
    step();
    check("resume_sel", out_sel, 2'd1);

    // Reset while holding a beat
    check("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_ready", in_ready, 4'b0000);
    step();
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_data", out_data, 4'h0);
    rst = 1'b0;
    #1;
    step();
    check("post_rst_sel", out_sel, 2'd0);
    check("post_rst_data", out_data, 4'hA);

    // Single requester 3, then 0 and 3
    do_reset();
    d3 = 4'h7;
    in_valid = 4'b1000;
    step();
    check("r3_sel", out_sel, 2'd3);
    check("r3_data", out_data, 4'h7);
    in_valid = 4'b1001;
    step();
    check("r3_next_sel", out_sel, 2'd0);
    d3 = 4'hD;

    // Burst from requester 1
    do_reset();
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    step();
    check("burst_b1", out_sel, 2'd1);
    in_valid = 4'b1111;
`ifdef ARB_RR_4_LOCK_EN
    #1;
    check("lock_ready", in_ready, 4'b0010);
    in_valid = 4'b1101;
    #1;
    check("lock_stall_ready", in_ready, 4'b0000);
    step();
    check("lock_stall_drain", out_valid, 1'b0);
    in_valid = 4'b1111;
    step();
    check("burst_b2", out_sel, 2'd1);
    in_last = 4'b0010;
    step();
    check("burst_b3", out_sel, 2'd1);
    in_last = 4'b0000;
    step();
    check("burst_after", out_sel, 2'd2);
`else
    step();
    check("burst_b2", out_sel, 2'd2);
    in_last = 4'b0010;
    step();
    check("burst_b3", out_sel, 2'd3);
    step();
    check("burst_after", out_sel, 2'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
